// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM
// states, captured-request payload and access-size helpers.
package dmem_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    // Request fields held for the duration of an access.
    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] wdata;
    } req_t;

    // Access size in bytes (1, 2 or 4); invalid codes fall into the word case.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: f3_size = 3'd1;
            F3_LH, F3_LHU: f3_size = 3'd2;
            default:       f3_size = 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) f3_legal = (f3 <= F3_SW);
        else    f3_legal = (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Word-organised RAM with per-byte write enables and a registered read.
// Ports: clk; en (access strobe); be[3:0] byte-lane write enables;
// addr word index; wdata 32-bit write data; rdata registered read data.
// Contents and read register are never reset.
module dmem_word_ram #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;

    // Read-before-write; read register only updates on an access.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// RISC-V data-memory controller: LB/LH/LW/LBU/LHU/SB/SH/SW with
// valid/ready request port and one-cycle response pulse. Accesses that
// cross a word boundary are split into two word accesses.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready handshake;
// req_we, req_f3, req_addr, req_wdata request fields; rsp_valid pulse with
// rsp_rdata (extended load data, 0 for stores/errors) and rsp_err.
// Build option: DMEM_MISALIGN_TRAP_EN makes any misaligned access a fault.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_f3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam int unsigned WA_W  = ADDR_W - 2;
    localparam int unsigned AE_W  = ADDR_W + 1;

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [31:0]       word0_q, word0_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              ram_en;
    logic [3:0]        ram_be;
    logic [WA_W-1:0]   ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // Acceptance-time fault check on the live request.
    logic [2:0]      in_size;
    logic [AE_W-1:0] in_end;
    logic            in_err;

    always_comb begin
        in_size = f3_size(req_f3);
        in_end  = AE_W'(req_addr) + AE_W'(in_size);
        in_err  = !f3_legal(req_we, req_f3) || (in_end > AE_W'(DEPTH_BYTES));
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((in_size == 3'd2 && req_addr[0]) ||
            (in_size == 3'd4 && req_addr[1:0] != 2'b00)) begin
            in_err = 1'b1;
        end
`endif
    end

    // Lane placement of the captured request across a two-word window.
    logic [2:0]      size;
    logic [1:0]      off;
    logic            crossing;
    logic [63:0]     st_data;
    logic [7:0]      st_be;
    logic [WA_W-1:0] word_idx;
    logic [31:0]     lo_word;
    logic [63:0]     ld_cat;
    logic [31:0]     ld_raw;
    logic [31:0]     ld_ext;

    always_comb begin
        size     = f3_size(req_q.f3);
        off      = addr_q[1:0];
        crossing = (3'(off) + size) > 3'd4;
        st_data  = 64'(req_q.wdata) << {off, 3'b000};
        st_be    = 8'(size_mask(size)) << off;
        word_idx = addr_q[ADDR_W-1:2];
        // Only a split access has its low word parked in word0.
        lo_word  = crossing ? word0_q : ram_rdata;
        ld_cat   = {ram_rdata, lo_word};
        ld_raw   = 32'(ld_cat >> {off, 3'b000});
        case (size)
            3'd1:    ld_ext = req_q.f3[2] ? {24'h0, ld_raw[7:0]}
                                          : {{24{ld_raw[7]}}, ld_raw[7:0]};
            3'd2:    ld_ext = req_q.f3[2] ? {16'h0, ld_raw[15:0]}
                                          : {{16{ld_raw[15]}}, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    // Next-state, capture and RAM control.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        err_d       = err_q;
        word0_d     = word0_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;
        ram_en      = 1'b0;
        ram_be      = 4'b0000;
        ram_addr    = word_idx;
        ram_wdata   = st_data[31:0];

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    req_d   = '{we: req_we, f3: req_f3, wdata: req_wdata};
                    addr_d  = req_addr;
                    err_d   = in_err;
                    state_d = in_err ? ST_RSP : ST_ACC0;
                end
            end
            ST_ACC0: begin
                ram_en  = 1'b1;
                ram_be  = req_q.we ? st_be[3:0] : 4'b0000;
                state_d = crossing ? ST_ACC1 : ST_RSP;
            end
            ST_ACC1: begin
                ram_en    = 1'b1;
                ram_addr  = word_idx + WA_W'(1);
                ram_wdata = st_data[63:32];
                ram_be    = req_q.we ? st_be[7:4] : 4'b0000;
                word0_d   = ram_rdata;
                state_d   = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rdata_d = (err_q || req_q.we) ? 32'h0 : ld_ext;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            word0_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            word0_q     <= word0_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    dmem_word_ram #(
        .WORDS (WORDS),
        .AW    (WA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
